// File: rtl/wb_bram_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_slave
// Description : Wishbone classic slave in front of a word-addressed memory.
//               Separate read/write wait-state latencies, byte-lane write
//               enables, base-address decode and a one-cycle acknowledge.
//               Aborted cycles never commit a write. In-window addresses
//               beyond DEPTH are acknowledged without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_slave #(
    parameter logic [7:0] BASE_ADDR = 8'h38,
    parameter int         DEPTH     = 1024,
    parameter int         RD_DELAYS = 10,
    parameter int         WR_DELAYS = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o,
    output logic [15:0] txn_cnt_o
);

    localparam int         c_aw   = $clog2(DEPTH);
    localparam logic [7:0] c_rd_d = 8'(RD_DELAYS);
    localparam logic [7:0] c_wr_d = 8'(WR_DELAYS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_we;
    logic [3:0]      r_sel;
    logic [31:0]     r_dat;
    logic [c_aw-1:0] r_idx;
    logic            r_inr;
    logic            r_ack;
    logic [31:0]     r_rdata;
    logic            r_busy;
    logic [15:0]     r_txn;

    logic [31:0]     r_mem [DEPTH];

    logic            w_hit;
    logic            w_hold;
    logic            w_inr_in;
    logic [c_aw-1:0] w_idx_in;
    logic [7:0]      w_d_in;
    logic [7:0]      w_d_lat;
    logic            w_go_ack;
    logic            w_we;
    logic [3:0]      w_sel;
    logic [31:0]     w_dat;
    logic [c_aw-1:0] w_idx;
    logic            w_inr;
    logic            w_commit;
    logic            w_unused;

    // Decode, latency selection and the transfer view used on the ACK-entry edge.
    // With a one-cycle latency the ACK is entered straight from IDLE, so the
    // live bus values are used there instead of the (not yet latched) copies.
    always_comb begin
        w_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR);
        w_hold   = wbs_cyc_i & wbs_stb_i;
        w_inr_in = (32'(wbs_adr_i[23:2]) < 32'(DEPTH));
        w_idx_in = wbs_adr_i[c_aw+1:2];
        w_d_in   = wbs_we_i ? c_wr_d : c_rd_d;
        w_d_lat  = r_we ? c_wr_d : c_rd_d;

        w_go_ack = ((r_state == S_IDLE) & w_hit & (w_d_in == 8'd1)) |
                   ((r_state == S_WAIT) & w_hold & (r_cnt == (w_d_lat - 8'd1)));

        w_we     = (r_state == S_IDLE) ? wbs_we_i  : r_we;
        w_sel    = (r_state == S_IDLE) ? wbs_sel_i : r_sel;
        w_dat    = (r_state == S_IDLE) ? wbs_dat_i : r_dat;
        w_idx    = (r_state == S_IDLE) ? w_idx_in  : r_idx;
        w_inr    = (r_state == S_IDLE) ? w_inr_in  : r_inr;

        // Reset on the same edge wins over a pending write.
        w_commit = w_go_ack & w_we & w_inr & ~wb_rst_i;
        w_unused = ^wbs_adr_i[1:0];
    end

    // Transaction FSM with registered ack, read data, busy and completion count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_dat   <= 32'd0;
            r_idx   <= '0;
            r_inr   <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
            r_busy  <= 1'b0;
            r_txn   <= 16'd0;
        end else begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_we  <= wbs_we_i;
                        r_sel <= wbs_sel_i;
                        r_dat <= wbs_dat_i;
                        r_idx <= w_idx_in;
                        r_inr <= w_inr_in;
                        r_cnt <= 8'd1;
                        if (w_go_ack) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_WAIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_hold) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_go_ack) begin
                        r_state <= S_ACK;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_go_ack) begin
                r_ack   <= 1'b1;
                r_txn   <= r_txn + 16'd1;
                r_rdata <= (!w_we && w_inr) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Byte-lane write into the memory array; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        for (int n = 0; n < 4; n++) begin
            if (w_commit && w_sel[n]) begin
                r_mem[w_idx][8*n +: 8] <= w_dat[8*n +: 8];
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;
    assign busy_o    = r_busy;
    assign txn_cnt_o = r_txn;

endmodule
`default_nettype wire
